// File: rtl/prefix_adder_accum_if.sv
// prefix_adder_accum_if
// Bundles the control, input-stream and output-stream signals of the
// prefix_adder_accum stage.
//   start/busy                       : transaction request and activity flag
//   in_valid/in_ready/in_data/in_cin : input beat stream (6-bit operand + carry-in)
//   out_valid/out_ready              : result handshake
//   out_sum/out_count                : modulo-64 sum and number of beats summed
// master : the side that feeds beats and consumes results
// slave  : the accumulation stage itself
interface prefix_adder_accum_if #(
  parameter int COUNT_W = 3
);
  logic               start;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic [5:0]         in_data;
  logic               in_cin;
  logic               out_valid;
  logic               out_ready;
  logic [5:0]         out_sum;
  logic [COUNT_W-1:0] out_count;

  modport master (
    output start, in_valid, in_data, in_cin, out_ready,
    input  busy, in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  start, in_valid, in_data, in_cin, out_ready,
    output busy, in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/prefix_adder_accum.sv
// prefix_adder
// 6-bit parallel-prefix (Kogge-Stone style) adder, s = x + y + c_in mod 64.
// Ports: x, y (6-bit operands), c_in (carry-in), s (6-bit sum).
// Only the prefix nodes that feed a carry are built; the carry-out is not
// needed downstream, so the bit-5 generate tree is pruned away.
module prefix_adder (
  input  logic [5:0] x,
  input  logic [5:0] y,
  input  logic       c_in,
  output logic [5:0] s
);
  logic [5:0] p0_s;
  logic [4:0] g0_s;
  logic [4:0] g1_s;
  logic [4:2] p1_s;
  logic [4:0] g2_s;
  logic       p2_4_s;
  logic       g3_4_s;

  assign p0_s = x ^ y;
  // c_in is folded into the bit-0 generate so every g*_s[i] is the carry out of bit i
  assign g0_s = {x[4:1] & y[4:1], (x[0] & y[0]) | (p0_s[0] & c_in)};

  // distance-1 combine
  assign g1_s = {g0_s[4:1] | (p0_s[4:1] & g0_s[3:0]), g0_s[0]};
  assign p1_s = p0_s[4:2] & p0_s[3:1];

  // distance-2 combine
  assign g2_s   = {g1_s[4:2] | (p1_s[4:2] & g1_s[2:0]), g1_s[1:0]};
  assign p2_4_s = p1_s[4] & p1_s[2];

  // distance-4 combine, only bit 4 reaches beyond the previous level
  assign g3_4_s = g2_s[4] | (p2_4_s & g2_s[0]);

  assign s = p0_s ^ {g3_4_s, g2_s[3:0], c_in};
endmodule

// prefix_adder_accum
// Clocked, handshaked accumulator around prefix_adder. After start it sums
// N_SAMPLES accepted beats (in_data + in_cin each) modulo 64 and presents
// the result on a valid/ready output.
// Ports: clk, rst_n (async active-low), bus (prefix_adder_accum_if.slave):
//   start, busy, in_valid, in_ready, in_data, in_cin,
//   out_valid, out_ready, out_sum, out_count.
module prefix_adder_accum #(
  parameter int N_SAMPLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prefix_adder_accum_if.slave  bus
);
  localparam int COUNT_W = $clog2(N_SAMPLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [5:0]         acc_r;
  logic [COUNT_W-1:0] cnt_r;
  logic [COUNT_W-1:0] cnt_inc_s;
  logic [5:0]         sum_s;
  logic               accept_s;
  logic               last_s;
  logic               clear_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [5:0]         out_sum_r;
  logic [COUNT_W-1:0] out_count_r;
  logic               in_ready_nxt_s;
  logic               out_valid_nxt_s;
  logic               busy_nxt_s;

  prefix_adder u_adder (
    .x    (acc_r),
    .y    (bus.in_data),
    .c_in (bus.in_cin),
    .s    (sum_s)
  );

  assign accept_s  = (state_r == ST_ACCUM) && bus.in_valid;
  assign cnt_inc_s = cnt_r + COUNT_W'(1);
  assign last_s    = accept_s && (cnt_r == COUNT_W'(N_SAMPLES - 1));
  // a new transaction opens from IDLE, or from HOLD when the result is taken in the same cycle
  assign clear_s   = bus.start &&
                     ((state_r == ST_IDLE) || ((state_r == ST_HOLD) && bus.out_ready));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (last_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_nxt_s = bus.start ? ST_ACCUM : ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // output decode from the upcoming state so the flags can be registered without lag
  always_comb begin
    in_ready_nxt_s  = 1'b0;
    out_valid_nxt_s = 1'b0;
    busy_nxt_s      = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
      end
      ST_ACCUM: begin
        in_ready_nxt_s  = 1'b1;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b1;
      end
      ST_HOLD: begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b1;
        busy_nxt_s      = 1'b1;
      end
      default: begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
      end
    endcase
  end

  // registered handshake and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // accumulator and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 6'd0;
      cnt_r <= '0;
    end else if (clear_s) begin
      acc_r <= 6'd0;
      cnt_r <= '0;
    end else if (accept_s) begin
      acc_r <= sum_s;
      cnt_r <= cnt_inc_s;
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  // result registers: loaded with the final beat, held through HOLD and IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum_r   <= 6'd0;
      out_count_r <= '0;
    end else if (last_s) begin
      out_sum_r   <= sum_s;
      out_count_r <= cnt_inc_s;
    end else begin
      out_sum_r   <= out_sum_r;
      out_count_r <= out_count_r;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_count = out_count_r;
endmodule

// File: tb/tb_prefix_adder_accum.sv
// Directed testbench for prefix_adder_accum (N_SAMPLES=4 main instance,
// N_SAMPLES=1 secondary instance).
module tb_prefix_adder_accum;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prefix_adder_accum_if #(.COUNT_W(CW)) bus ();
  prefix_adder_accum_if #(.COUNT_W(1))  bus1 ();

  prefix_adder_accum #(.N_SAMPLES(N)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  prefix_adder_accum #(.N_SAMPLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic beat(input logic [5:0] d, input logic c);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_cin   = c;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 6'd0;
    bus.in_cin   = 1'b0;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {bus.out_valid, bus.in_ready, bus.busy});
    end
    checks++;
    if ({bus.out_sum, bus.out_count} !== {6'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_result: got sum=%0d cnt=%0d expected 0/0", bus.out_sum, bus.out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 000", {bus.out_valid, bus.in_ready, bus.busy});
    end
  endtask

  task automatic test_basic();
    go();
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b011) begin
      errors++;
      $display("FAIL basic_accum_flags: got %b expected 011", {bus.out_valid, bus.in_ready, bus.busy});
    end
    beat(6'd10, 1'b0);
    beat(6'd20, 1'b0);
    beat(6'd30, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: got %b expected 0", bus.out_valid);
    end
    beat(6'd5, 1'b0);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b101) begin
      errors++;
      $display("FAIL basic_hold_flags: got %b expected 101", {bus.out_valid, bus.in_ready, bus.busy});
    end
    checks++;
    if ({bus.out_sum, bus.out_count} !== {6'd1, 3'd4}) begin
      errors++;
      $display("FAIL basic_result: got sum=%0d cnt=%0d expected 1/4", bus.out_sum, bus.out_count);
    end
    take_result();
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.out_sum, bus.out_count} !== {3'b000, 6'd1, 3'd4}) begin
      errors++;
      $display("FAIL basic_idle_retain: got flags=%b sum=%0d cnt=%0d expected 000/1/4",
               {bus.out_valid, bus.in_ready, bus.busy}, bus.out_sum, bus.out_count);
    end
  endtask

  task automatic test_wrap();
    go();
    for (int i = 0; i < 4; i++) beat(6'd63, 1'b1);
    checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_count} !== {1'b1, 6'd0, 3'd4}) begin
      errors++;
      $display("FAIL wrap_cin1: got v=%b sum=%0d cnt=%0d expected 1/0/4", bus.out_valid, bus.out_sum, bus.out_count);
    end
    take_result();
    go();
    for (int i = 0; i < 4; i++) beat(6'd63, 1'b0);
    checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_count} !== {1'b1, 6'd60, 3'd4}) begin
      errors++;
      $display("FAIL wrap_cin0: got v=%b sum=%0d cnt=%0d expected 1/60/4", bus.out_valid, bus.out_sum, bus.out_count);
    end
    take_result();
  endtask

  task automatic test_gaps();
    go();
    for (int i = 1; i <= 4; i++) begin
      beat(6'(i), 1'b0);
      if (i < 4) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          checks++;
          if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b011) begin
            errors++;
            $display("FAIL gap_flags: beat %0d gap %0d got %b expected 011", i, g,
                     {bus.out_valid, bus.in_ready, bus.busy});
          end
        end
      end
    end
    checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_count} !== {1'b1, 6'd10, 3'd4}) begin
      errors++;
      $display("FAIL gap_result: got v=%b sum=%0d cnt=%0d expected 1/10/4", bus.out_valid, bus.out_sum, bus.out_count);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    go();
    beat(6'd5, 1'b0);
    beat(6'd6, 1'b0);
    beat(6'd7, 1'b0);
    beat(6'd8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.busy, bus.out_sum, bus.out_count} !== {3'b101, 6'd26, 3'd4}) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d got flags=%b sum=%0d cnt=%0d expected 101/26/4", i,
                 {bus.out_valid, bus.in_ready, bus.busy}, bus.out_sum, bus.out_count);
      end
    end
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b011) begin
      errors++;
      $display("FAIL b2b_flags: got %b expected 011", {bus.out_valid, bus.in_ready, bus.busy});
    end
    for (int i = 0; i < 4; i++) beat(6'd7, 1'b0);
    checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_count} !== {1'b1, 6'd28, 3'd4}) begin
      errors++;
      $display("FAIL b2b_result: got v=%b sum=%0d cnt=%0d expected 1/28/4", bus.out_valid, bus.out_sum, bus.out_count);
    end
    take_result();
  endtask

  task automatic test_async_reset();
    go();
    beat(6'd9, 1'b0);
    beat(6'd9, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.out_sum, bus.out_count} !== {3'b000, 6'd0, 3'd0}) begin
      errors++;
      $display("FAIL async_reset: got flags=%b sum=%0d cnt=%0d expected 000/0/0",
               {bus.out_valid, bus.in_ready, bus.busy}, bus.out_sum, bus.out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    go();
    for (int i = 0; i < 4; i++) beat(6'd1, 1'b0);
    checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_count} !== {1'b1, 6'd4, 3'd4}) begin
      errors++;
      $display("FAIL post_reset_result: got v=%b sum=%0d cnt=%0d expected 1/4/4", bus.out_valid, bus.out_sum, bus.out_count);
    end
    take_result();
  endtask

  task automatic test_start_ignored();
    go();
    beat(6'd3, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    beat(6'd4, 1'b0);
    beat(6'd5, 1'b0);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b011) begin
      errors++;
      $display("FAIL start_accum_flags: got %b expected 011", {bus.out_valid, bus.in_ready, bus.busy});
    end
    bus.start = 1'b1;
    beat(6'd6, 1'b0);
    bus.start = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_count} !== {1'b1, 6'd18, 3'd4}) begin
      errors++;
      $display("FAIL start_accum_result: got v=%b sum=%0d cnt=%0d expected 1/18/4", bus.out_valid, bus.out_sum, bus.out_count);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.out_sum, bus.out_count} !== {3'b101, 6'd18, 3'd4}) begin
      errors++;
      $display("FAIL start_in_hold: got flags=%b sum=%0d cnt=%0d expected 101/18/4",
               {bus.out_valid, bus.in_ready, bus.busy}, bus.out_sum, bus.out_count);
    end
    take_result();
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL start_release_idle: got %b expected 000", {bus.out_valid, bus.in_ready, bus.busy});
    end
  endtask

  task automatic test_single_sample();
    bus1.start = 1'b1;
    tick();
    bus1.start    = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_data  = 6'd33;
    bus1.in_cin   = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    bus1.in_data  = 6'd0;
    bus1.in_cin   = 1'b0;
    checks++;
    if ({bus1.out_valid, bus1.in_ready, bus1.out_sum, bus1.out_count} !== {2'b10, 6'd34, 1'b1}) begin
      errors++;
      $display("FAIL single_sample: got v=%b rdy=%b sum=%0d cnt=%0d expected 1/0/34/1",
               bus1.out_valid, bus1.in_ready, bus1.out_sum, bus1.out_count);
    end
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 6'd0;
    bus.in_cin     = 1'b0;
    bus.out_ready  = 1'b0;
    bus1.start     = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 6'd0;
    bus1.in_cin    = 1'b0;
    bus1.out_ready = 1'b0;

    test_reset();
    test_basic();
    test_wrap();
    test_gaps();
    test_back_to_back();
    test_async_reset();
    test_start_ignored();
    test_single_sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prefix_adder_accum.md
Name: prefix_adder_accum

Overview:
Sequential accumulation stage that sits directly downstream of the 6-bit prefix_adder.
- Instantiates one prefix_adder, feeds X from its own accumulator register and Y/c_in from an input stream, and registers S back into the accumulator.
- After N_SAMPLES accepted beats it presents the modulo-64 sum on a valid/ready output port.
- Gives the combinational adder a clocked, handshaked wrapper for use in streaming datapaths.

Parameters:
N_SAMPLES, 4, number of input beats summed per transaction; legal range 1..255.
COUNT_W, $clog2(N_SAMPLES+1), width of the beat counter and out_count; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a transaction
busy  output  1  high in ACCUM and HOLD
in_valid  input  1  input beat valid
in_ready  output  1  stage accepts a beat
in_data  input  6  operand driven to adder Y
in_cin  input  1  per-beat carry-in driven to adder c_in
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  6  accumulated sum, modulo 64
out_count  output  COUNT_W  beats summed; equals N_SAMPLES when out_valid=1

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0:
  - state=IDLE, acc=0, cnt=0;
  - out_valid=0, in_ready=0, busy=0, out_sum=0, out_count=0.
  - Deassertion takes effect at the next rising clk edge.
- Adder hookup: X=acc, Y=in_data, c_in=in_cin, all combinational. S is captured only on an accepted beat. Arithmetic wraps modulo 64; no carry-out or overflow flag is produced.
- State IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - start=1 → acc<=0, cnt<=0, next state ACCUM.
- State ACCUM:
  - in_ready=1, busy=1, out_valid=0.
  - Beat accepted when in_valid=1 and in_ready=1: acc<=S, cnt<=cnt+1.
  - Accepting the beat that makes cnt reach N_SAMPLES → next state HOLD. Result visible the cycle after the last beat, so latency is 1 cycle from last accept to out_valid.
  - in_valid=0 cycles are idle; acc and cnt hold.
  - start is ignored.
- State HOLD:
  - out_valid=1, out_sum=acc, out_count=cnt, in_ready=0, busy=1.
  - out_sum and out_count are stable while out_valid=1 and out_ready=0.
  - out_ready=1 → handshake completes. Next state is IDLE, or ACCUM with acc<=0, cnt<=0 if start=1 in the same cycle (back-to-back, no idle bubble).
  - start without out_ready is ignored.
- out_sum and out_count are registered outputs. They retain their last values in IDLE and are cleared only by reset.
- N_SAMPLES=1: a single beat moves ACCUM→HOLD.
- Reset asserted mid-ACCUM or mid-HOLD: partial sum discarded, outputs return to reset values immediately (asynchronously).
- The stage ignores in_data/in_cin X-values when in_ready=0. No assertion fires.

Test Plan:
- Reset, then start, then beats 10,20,30,5 with in_cin=0 each cycle (N_SAMPLES=4) → out_valid rises 1 cycle after the 4th beat; out_sum=1 (65 mod 64); out_count=4.
- Beats 63,63,63,63 with in_cin=1 → out_sum=0 (each step adds 64). Repeat with in_cin=0 → out_sum=60 (252 mod 64).
- Beats 1,2,3,4 with in_valid low for 2 cycles between each beat → in_ready stays 1; out_sum=10 only after the 4th accept; acc unchanged on gap cycles.
- In HOLD with out_ready=0 for 5 cycles → out_valid, out_sum, out_count constant. out_ready=1 together with start=1 → next cycle state ACCUM, busy=1, in_ready=1, out_valid=0. A new transaction 7,7,7,7 → out_sum=28.
- rst_n pulsed low asynchronously (mid-cycle) after 2 beats → out_valid=0, in_ready=0, busy=0 immediately. After release, start plus 4 beats of 1 → out_sum=4, not including the pre-reset beats.
- start pulses during ACCUM and during HOLD without out_ready → no effect: cnt unchanged, acc unchanged, final result matches the undisturbed sum.
